// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: issue/stall/flush control between IF/ID and EX, with RAW
// detection through shadow EX/WB slots, forwarding select and saturating counters.
module pipeline_sequencer #(
    parameter int REG_W       = 3,
    parameter int FILL_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             id_valid,
    input  logic [1:0]       id_opcode,
    input  logic [REG_W-1:0] id_rd,
    input  logic [REG_W-1:0] id_rs,
    output logic             issue,
    output logic             stall_if,
    output logic             flush_if_id,
    output logic             ctrl_regwrite,
    output logic             ctrl_jump,
    output logic             ctrl_valsel,
    output logic [1:0]       fwd_sel,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cnt_issue,
    output logic [CNT_W-1:0] cnt_stall
);
    localparam int FW = $clog2(FILL_CYCLES + 1);

    typedef enum logic [1:0] {FILL = 2'b00, RUN = 2'b01, FLUSH = 2'b10, HOLD = 2'b11} state_t;

    state_t           cur, nxt;
    logic [FW-1:0]    fill_cnt;
    logic             ex_valid, ex_wr, wb_valid, wb_wr;
    logic [REG_W-1:0] ex_rd, wb_rd;
    logic             is_addi, raw, frozen;

    assign is_addi = id_valid & (id_opcode == 2'b01);
    assign raw     = is_addi & ex_valid & ex_wr & (ex_rd == id_rs);
    assign frozen  = hold & (cur != FILL);

    assign issue         = (cur == RUN) & ~hold & ~raw & id_valid;
    assign stall_if      = ((cur == RUN) & (hold | raw)) | (cur == HOLD) | ((cur == FLUSH) & hold);
    assign flush_if_id   = (cur == FLUSH) | (issue & id_opcode[1]);
    assign ctrl_regwrite = issue & ~id_opcode[1];
    assign ctrl_jump     = issue & id_opcode[1];
    assign ctrl_valsel   = issue & id_opcode[0] & ~id_opcode[1];
    assign fwd_sel       = {1'b0, issue & is_addi & wb_valid & wb_wr & (wb_rd == id_rs)};
    assign state         = cur;

    // FLUSH and HOLD both release to RUN on the first cycle hold is low
    always_comb begin
        nxt = cur;
        case (cur)
            FILL:    nxt = (fill_cnt <= FW'(1)) ? RUN : FILL;
            RUN:     nxt = hold ? HOLD : (issue & id_opcode[1]) ? FLUSH : RUN;
            default: nxt = hold ? cur : RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= FILL;
            fill_cnt  <= FW'(FILL_CYCLES);
            ex_valid  <= 1'b0;
            ex_wr     <= 1'b0;
            ex_rd     <= '0;
            wb_valid  <= 1'b0;
            wb_wr     <= 1'b0;
            wb_rd     <= '0;
            cnt_issue <= '0;
            cnt_stall <= '0;
        end else begin
            cur <= nxt;
            if (cur == FILL)
                fill_cnt <= fill_cnt - FW'(1);
            if (!frozen) begin
                ex_valid <= issue;
                ex_wr    <= ctrl_regwrite;
                ex_rd    <= id_rd;
                wb_valid <= ex_valid;
                wb_wr    <= ex_wr;
                wb_rd    <= ex_rd;
            end
            if (issue && cnt_issue != '1)
                cnt_issue <= cnt_issue + CNT_W'(1);
            if (stall_if && cnt_stall != '1)
                cnt_stall <= cnt_stall + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed scenarios plus random traffic, checked every
// cycle against a history-based behavioural model of the sequencer.
module tb_pipeline_sequencer;
    localparam int REG_W = 3;
    localparam int FILL_CYCLES = 2;

    logic clk = 1'b0;
    logic rst, hold, id_valid;
    logic [1:0] id_opcode;
    logic [REG_W-1:0] id_rd, id_rs;
    logic issue, stall_if, flush_if_id, ctrl_regwrite, ctrl_jump, ctrl_valsel;
    logic [1:0] fwd_sel, state;
    logic [15:0] cnt_issue, cnt_stall;
    logic issue4, stall4, flush4, rw4, jmp4, vs4;
    logic [1:0] fwd4, state4;
    logic [3:0] cnt_issue4, cnt_stall4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_sequencer #(.REG_W(REG_W), .FILL_CYCLES(FILL_CYCLES), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs(id_rs), .issue(issue), .stall_if(stall_if),
        .flush_if_id(flush_if_id), .ctrl_regwrite(ctrl_regwrite), .ctrl_jump(ctrl_jump),
        .ctrl_valsel(ctrl_valsel), .fwd_sel(fwd_sel), .state(state),
        .cnt_issue(cnt_issue), .cnt_stall(cnt_stall));

    pipeline_sequencer #(.REG_W(REG_W), .FILL_CYCLES(FILL_CYCLES), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs(id_rs), .issue(issue4), .stall_if(stall4),
        .flush_if_id(flush4), .ctrl_regwrite(rw4), .ctrl_jump(jmp4),
        .ctrl_valsel(vs4), .fwd_sel(fwd4), .state(state4),
        .cnt_issue(cnt_issue4), .cnt_stall(cnt_stall4));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: mode uses the published state codes; in-flight writers are a history
    // of what entered EX (newest last), so EX is hist[$] and WB is hist[$-1].
    typedef struct {bit w; int rd;} ent_t;
    ent_t hist[$];
    int m_mode, m_fill, m_ci, m_cs, m_ci4, m_cs4;

    always @(negedge clk) begin
        bit e_iss, e_stl, e_fl, e_fwd, ex_w, wb_w, addi;
        int ex_rd, wb_rd, nxt;
        if (rst) begin
            m_mode = 0; m_fill = FILL_CYCLES; hist.delete();
            m_ci = 0; m_cs = 0; m_ci4 = 0; m_cs4 = 0;
            e_iss = 0; e_stl = 0; e_fl = 0; e_fwd = 0; addi = 0;
        end else begin
            ex_w = hist.size() > 0 && hist[hist.size()-1].w;
            ex_rd = hist.size() > 0 ? hist[hist.size()-1].rd : 0;
            wb_w = hist.size() > 1 && hist[hist.size()-2].w;
            wb_rd = hist.size() > 1 ? hist[hist.size()-2].rd : 0;
            addi = id_valid && id_opcode == 2'b01;
            e_iss = 0; e_stl = 0; e_fl = 0; nxt = m_mode;
            case (m_mode)
                0: begin m_fill--; if (m_fill == 0) nxt = 1; end
                1: if (hold) begin e_stl = 1; nxt = 3; end
                   else if (addi && ex_w && ex_rd == int'(id_rs)) e_stl = 1;
                   else if (id_valid) begin
                       e_iss = 1;
                       if (id_opcode[1]) begin e_fl = 1; nxt = 2; end
                   end
                2: begin e_fl = 1; e_stl = hold; if (!hold) nxt = 1; end
                default: begin e_stl = 1; if (!hold) nxt = 1; end
            endcase
            e_fwd = e_iss && addi && wb_w && wb_rd == int'(id_rs);
        end
        chk("issue", int'(issue), int'(e_iss));
        chk("stall_if", int'(stall_if), int'(e_stl));
        chk("flush_if_id", int'(flush_if_id), int'(e_fl));
        chk("ctrl_regwrite", int'(ctrl_regwrite), int'(e_iss && !id_opcode[1]));
        chk("ctrl_jump", int'(ctrl_jump), int'(e_iss && id_opcode[1]));
        chk("ctrl_valsel", int'(ctrl_valsel), int'(e_iss && id_opcode == 2'b01));
        chk("fwd_sel", int'(fwd_sel), int'(e_fwd));
        chk("state", int'(state), m_mode);
        chk("cnt_issue", int'(cnt_issue), m_ci);
        chk("cnt_stall", int'(cnt_stall), m_cs);
        chk("cnt_issue4", int'(cnt_issue4), m_ci4);
        chk("cnt_stall4", int'(cnt_stall4), m_cs4);
        if (!rst) begin
            if (!(hold && m_mode != 0)) begin
                hist.push_back('{w: e_iss && !id_opcode[1], rd: int'(id_rd)});
                if (hist.size() > 2) void'(hist.pop_front());
            end
            if (e_iss) begin
                m_ci = m_ci < 65535 ? m_ci + 1 : m_ci;
                m_ci4 = m_ci4 < 15 ? m_ci4 + 1 : m_ci4;
            end
            if (e_stl) begin
                m_cs = m_cs < 65535 ? m_cs + 1 : m_cs;
                m_cs4 = m_cs4 < 15 ? m_cs4 + 1 : m_cs4;
            end
            m_mode = nxt;
        end
    end

    task automatic cyc(input bit h, input bit v, input logic [1:0] op, input int rd, input int rs);
        @(posedge clk);
        #1;
        hold = h; id_valid = v; id_opcode = op; id_rd = REG_W'(rd); id_rs = REG_W'(rs);
        @(negedge clk);
    endtask

    int s0;

    initial begin
        rst = 1; hold = 0; id_valid = 1; id_opcode = 2'b00; id_rd = 1; id_rs = 0;
        @(negedge clk);
        chk("rst_issue", int'(issue), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_flush", int'(flush_if_id), 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("fill1_issue", int'(issue), 0);
        chk("fill1_state", int'(state), 0);
        cyc(0, 1, 2'b00, 1, 0);
        chk("fill2_issue", int'(issue), 0);
        cyc(0, 1, 2'b00, 3, 0);
        chk("run_state", int'(state), 1);
        chk("first_issue", int'(issue), 1);
        cyc(0, 1, 2'b01, 5, 3);
        chk("raw_stall", int'(stall_if), 1);
        chk("raw_issue", int'(issue), 0);
        cyc(0, 1, 2'b01, 5, 3);
        chk("raw_reissue", int'(issue), 1);
        chk("raw_fwd", int'(fwd_sel), 1);
        cyc(0, 1, 2'b10, 0, 0);
        chk("raw_cnt_issue", int'(cnt_issue), 2);
        chk("raw_cnt_stall", int'(cnt_stall), 1);
        chk("j_jump", int'(ctrl_jump), 1);
        chk("j_flush", int'(flush_if_id), 1);
        cyc(0, 1, 2'b00, 6, 0);
        chk("flush_state", int'(state), 2);
        chk("flush_flush", int'(flush_if_id), 1);
        chk("flush_issue", int'(issue), 0);
        cyc(0, 1, 2'b00, 6, 0);
        chk("post_flush_issue", int'(issue), 1);
        s0 = int'(cnt_stall);
        cyc(1, 1, 2'b01, 7, 6);
        chk("hold_stall", int'(stall_if), 1);
        cyc(1, 1, 2'b01, 7, 6);
        chk("hold_state", int'(state), 3);
        cyc(1, 1, 2'b01, 7, 6);
        cyc(0, 1, 2'b01, 7, 6);
        chk("hold_release_stall", int'(stall_if), 1);
        cyc(0, 1, 2'b01, 7, 6);
        chk("post_hold_fwd", int'(fwd_sel), 1);
        chk("hold_cnt_stall", int'(cnt_stall), s0 + 4);
        cyc(0, 1, 2'b10, 0, 0);
        cyc(1, 1, 2'b00, 1, 0);
        chk("flush_hold_state", int'(state), 2);
        chk("flush_hold_stall", int'(stall_if), 1);
        cyc(1, 1, 2'b00, 1, 0);
        chk("flush_hold_state2", int'(state), 2);
        cyc(0, 1, 2'b00, 1, 0);
        chk("flush_hold_rel", int'(flush_if_id), 1);
        cyc(0, 1, 2'b00, 1, 0);
        chk("flush_hold_run", int'(state), 1);
        cyc(0, 1, 2'b10, 0, 0);
        @(posedge clk);
        #1 id_opcode = 2'b00;
        #1 rst = 1;
        @(negedge clk);
        chk("midrst_state", int'(state), 0);
        chk("midrst_flush", int'(flush_if_id), 0);
        chk("midrst_cnt", int'(cnt_issue), 0);
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 499) == 0);
            hold = ($urandom_range(0, 7) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_opcode = 2'($urandom_range(0, 3));
            id_rd = REG_W'($urandom);
            id_rs = REG_W'($urandom);
        end
        for (int i = 0; i < 25; i++) cyc(0, 1, 2'b00, 1, 0);
        chk("sat_issue4", int'(cnt_issue4), 15);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
